// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-side and serial-line signals of fifo_uart_tx.
interface fifo_uart_tx_if #(parameter int DATA_W = 8);
   logic              tx_enable;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_read_en;
   logic              txd;
   logic              busy;
   logic              tx_done;
   modport master (output tx_enable, fifo_empty, fifo_data_out, input fifo_read_en, txd, busy, tx_done);
   modport slave (input tx_enable, fifo_empty, fifo_data_out, output fifo_read_en, txd, busy, tx_done);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO byte by byte and serialises each as a UART frame (start, data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input logic           clk,
   input logic           rst_n,
   fifo_uart_tx_if.slave bus
);
   localparam int BAW = $clog2(CLKS_PER_BIT);
   localparam int BCW = $clog2(DATA_W);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, PARITY, STOP} state_t;
   logic parity;
`else
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP} state_t;
`endif
   state_t            state;
   logic [BAW-1:0]    baud_cnt;
   logic [BCW-1:0]    bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic              last;
   assign last = baud_cnt == BAW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         bus.txd          <= 1'b1;
         bus.fifo_read_en <= 1'b0;
         bus.busy         <= 1'b0;
         bus.tx_done      <= 1'b0;
         baud_cnt         <= '0;
         bit_cnt          <= '0;
         shift_reg        <= '0;
`ifdef UART_TX_PARITY_EN
         parity           <= 1'b0;
`endif
      end else begin
         bus.fifo_read_en <= 1'b0;
         bus.tx_done      <= 1'b0;
         case (state)
            IDLE: if (bus.tx_enable && !bus.fifo_empty) begin
               state            <= FETCH;
               bus.fifo_read_en <= 1'b1;
               bus.busy         <= 1'b1;
            end
            FETCH: state <= CAPTURE;
            // FIFO read data is registered, so it is valid here, one cycle after the strobe
            CAPTURE: begin
               shift_reg <= bus.fifo_data_out;
`ifdef UART_TX_PARITY_EN
               parity    <= ^bus.fifo_data_out;
`endif
               bus.txd   <= 1'b0;
               baud_cnt  <= '0;
               state     <= START;
            end
            START: if (last) begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               bus.txd  <= shift_reg[0];
               state    <= DATA;
            end else baud_cnt <= baud_cnt + 1'b1;
            DATA: if (last) begin
               baud_cnt  <= '0;
               bit_cnt   <= bit_cnt + 1'b1;
               shift_reg <= shift_reg >> 1;
               if (bit_cnt == BCW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  bus.txd <= parity;
                  state   <= PARITY;
`else
                  bus.txd <= 1'b1;
                  state   <= STOP;
`endif
               end else bus.txd <= shift_reg[1];
            end else baud_cnt <= baud_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) begin
               baud_cnt <= '0;
               bus.txd  <= 1'b1;
               state    <= STOP;
            end else baud_cnt <= baud_cnt + 1'b1;
`endif
            STOP: if (last) begin
               baud_cnt    <= '0;
               bus.busy    <= 1'b0;
               bus.tx_done <= 1'b1;
               state       <= IDLE;
            end else baud_cnt <= baud_cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random and directed stimulus against a frame-timeline model of fifo_uart_tx.
// The model predicts every output cycle from the sampling edge of each frame; literal frames pin it.
module tb_fifo_uart_tx;
   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int NB = 10;
   localparam bit PAR = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0, errors = 0;
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   logic [NB-1:0] frames_q[$];
   int rd_cnt = 0, done_cnt = 0, fall_cnt = 0, ncyc = 0;
   int rd_cyc = 0, done_cyc = 0, last_lat = -1, last_gap = -1;
   fifo_uart_tx_if #(.DATA_W(8)) bus();
   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] fl(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
      return {1'b1, p, d, 1'b0};
`else
      return p ? {1'b1, d, 1'b0} : {1'b1, d, 1'b0};
`endif
   endfunction

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic wait_done(input int target, input string name);
      int i = 0;
      while (done_cnt < target && i < 500) begin
         @(negedge clk);
         i++;
      end
      chk(name, int'(done_cnt >= target), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_fall(input int target);
      int i = 0;
      while (fall_cnt < target && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk("wait_txd_fall", int'(fall_cnt >= target), 1);
   endtask

   task automatic check_frame(input string name, input logic [NB-1:0] exp);
      logic [NB-1:0] f = '0;
      if (frames_q.size() > 0) f = frames_q.pop_front();
      chk(name, int'(f), int'(exp));
   endtask

   // FIFO with registered read data: a strobe seen before an edge pops on that edge
   initial begin
      logic rd_prev = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_data_out = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rd_prev && fq.size() > 0) bus.fifo_data_out = fq.pop_front();
         rd_prev = bus.fifo_read_en;
         bus.fifo_empty = fq.size() == 0;
      end
   end

   // Frame decoder: samples mid-bit after each txd fall, records latency and gaps
   initial begin
      logic act = 1'b0, prev = 1'b1;
      int m = 0;
      logic [NB-1:0] fr = '0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (!rst_n) begin
            act = 1'b0;
            prev = 1'b1;
            continue;
         end
         if (bus.fifo_read_en) begin rd_cnt++; rd_cyc = ncyc; end
         if (bus.tx_done) begin done_cnt++; done_cyc = ncyc; end
         if (!act && prev && !bus.txd) begin
            act = 1'b1;
            m = 0;
            fr = '0;
            fall_cnt++;
            last_lat = ncyc - rd_cyc;
            last_gap = ncyc - done_cyc;
         end
         if (act) begin
            if (m % C == C / 2) fr[m / C] = bus.txd;
            m++;
            if (m == NB * C) begin
               act = 1'b0;
               frames_q.push_back(fr);
            end
         end
         prev = bus.txd;
      end
   end

   // Timeline model: a frame starts at an edge where the idle transmitter sees enable and data
   initial begin
      int n = 0, fs = 0, d, k;
      bit inf = 1'b0, done_e;
      logic [7:0] cur = '0;
      logic e_txd, e_busy, e_rd, e_done;
      forever begin
         @(posedge clk);
         n++;
         done_e = 1'b0;
         if (!rst_n) inf = 1'b0;
         else if (inf && n == fs + 2 + NB * C) begin
            inf = 1'b0;
            done_e = 1'b1;
         end else if (!inf && bus.tx_enable && !bus.fifo_empty && exp_q.size() > 0) begin
            inf = 1'b1;
            fs = n;
            cur = exp_q.pop_front();
         end
         if (!inf) begin
            e_txd = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = done_e;
         end else begin
            d = n - fs;
            e_rd = d == 0; e_busy = 1'b1; e_done = 1'b0;
            k = (d - 2) / C;
            e_txd = d < 2 ? 1'b1 : k == 0 ? 1'b0 : k <= 8 ? cur[k-1] : (PAR && k == 9) ? ^cur : 1'b1;
         end
         @(negedge clk);
         if (!rst_n) begin
            e_txd = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
         end
         chk("txd", int'(bus.txd), int'(e_txd));
         chk("busy", int'(bus.busy), int'(e_busy));
         chk("fifo_read_en", int'(bus.fifo_read_en), int'(e_rd));
         chk("tx_done", int'(bus.tx_done), int'(e_done));
      end
   end

   initial begin
      int r0, d0, f0, np;
      rst_n = 1'b0;
      bus.tx_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (50) @(posedge clk);
      chk("reset_no_read", rd_cnt, 0);
      chk("reset_no_done", done_cnt, 0);
      chk("reset_txd_idle", int'(bus.txd), 1);

      @(negedge clk); r0 = rd_cnt; d0 = done_cnt;
      push(8'hA5);
      wait_done(d0 + 1, "a5_done");
      chk("a5_reads", rd_cnt - r0, 1);
      chk("a5_done_once", done_cnt - d0, 1);
      chk("a5_start_latency", last_lat, 2);
      check_frame("a5_frame", fl(8'hA5, 1'b0));

      @(negedge clk); r0 = rd_cnt; d0 = done_cnt;
      push(8'h01); push(8'h80);
      wait_done(d0 + 2, "b2b_done");
      chk("b2b_reads", rd_cnt - r0, 2);
      chk("b2b_gap", last_gap, 3);
      check_frame("b2b_frame0", fl(8'h01, 1'b1));
      check_frame("b2b_frame1", fl(8'h80, 1'b1));

      @(negedge clk); r0 = rd_cnt; d0 = done_cnt; f0 = fall_cnt;
      push(8'h3C); push(8'h55);
      wait_fall(f0 + 1);
      repeat (4 * C + 1) @(negedge clk);
      bus.tx_enable = 1'b0;
      wait_done(d0 + 1, "en_drop_done");
      check_frame("en_drop_frame", fl(8'h3C, 1'b0));
      repeat (60) @(negedge clk);
      chk("en_drop_reads", rd_cnt - r0, 1);
      chk("en_drop_no_frame", done_cnt - d0, 1);
      bus.tx_enable = 1'b1;
      wait_done(d0 + 2, "en_resume_done");
      check_frame("en_resume_frame", fl(8'h55, 1'b0));

      @(negedge clk); f0 = fall_cnt;
      push(8'h96);
      wait_fall(f0 + 1);
      repeat (2 * C) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_txd", int'(bus.txd), 1);
      chk("async_rst_busy", int'(bus.busy), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      r0 = rd_cnt; d0 = done_cnt;
      repeat (40) @(negedge clk);
      chk("post_rst_reads", rd_cnt - r0, 0);
      chk("post_rst_done", done_cnt - d0, 0);
      chk("post_rst_frames", frames_q.size(), 0);

      @(negedge clk); d0 = done_cnt;
      push(8'h07); push(8'h03);
      wait_done(d0 + 2, "par_done");
      check_frame("par_frame_07", fl(8'h07, 1'b1));
      check_frame("par_frame_03", fl(8'h03, 1'b0));

      d0 = done_cnt; np = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) != 0) begin
            push(8'($urandom));
            np++;
         end
         bus.tx_enable = $urandom_range(0, 4) != 0;
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      bus.tx_enable = 1'b1;
      for (int i = 0; i < 10000 && (fq.size() > 0 || bus.busy); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("rand_drained", int'(fq.size() == 0 && !bus.busy), 1);
      chk("rand_frames", done_cnt - d0, np);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
